// File: rtl/seg_pkg.sv
// Shared definitions for multiplexed 7-segment display blocks:
// scan FSM states, output polarity constants and the hex font.
package seg_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_ON   = 2'd2,
        S_DIM  = 2'd3
    } seg_state_t;

    localparam bit POL_ACT_HIGH = 1'b0;
    localparam bit POL_ACT_LOW  = 1'b1;

    // gfedcba patterns; digit 0 in the low slice, digit F in the high slice
    localparam logic [16*7-1:0] SEG_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        return SEG_FONT[7*int'(nib) +: 7];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-side bundle of the 7-segment scan controller: display content
// and scan controls in, segment/common drive and frame marker out.
interface seg_scan_ctrl_if #(
    parameter int N_DIGIT  = 8,
    parameter int BRIGHT_W = 2
);
    logic                   i_en;
    logic                   i_pls_tick;
    logic [4*N_DIGIT-1:0]   i_data;
    logic [N_DIGIT-1:0]     i_dot;
    logic                   i_lzs_en;
    logic [BRIGHT_W:0]      i_bright;
    logic [7:0]             o_seg_d;
    logic [N_DIGIT-1:0]     o_seg_com;
    logic                   o_frame_start;

    modport master (
        output i_en, i_pls_tick, i_data, i_dot, i_lzs_en, i_bright,
        input  o_seg_d, o_seg_com, o_frame_start
    );

    modport slave (
        input  i_en, i_pls_tick, i_data, i_dot, i_lzs_en, i_bright,
        output o_seg_d, o_seg_com, o_frame_start
    );
endinterface

// File: rtl/seg_hex_font.sv
// Combinational hex nibble to gfedcba segment pattern.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = seg_font(i_nib);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: MSD-first digit scan with dead time,
// PWM brightness, leading-zero suppression and frame-synchronous input shadows.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGIT     = 8,
    parameter int BRIGHT_W    = 2,
    parameter int DEAD_TICKS  = 1,
    parameter bit SEG_ACT_LOW = POL_ACT_HIGH,
    parameter bit COM_ACT_LOW = POL_ACT_HIGH
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    seg_scan_ctrl_if.slave bus
);
    localparam int                  DIG_W    = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(N_DIGIT - 1);
    localparam logic [BRIGHT_W-1:0] SUB_LAST = '1;
    localparam logic [7:0]          SEG_IDLE = {8{SEG_ACT_LOW}};
    localparam logic [N_DIGIT-1:0]  COM_IDLE = {N_DIGIT{COM_ACT_LOW}};

    seg_state_t           r_state, w_state_nx;
    logic [BRIGHT_W-1:0]  r_sub_cnt, w_sub_nx;
    logic [DIG_W-1:0]     r_dig_idx, w_dig_nx;
    logic [4*N_DIGIT-1:0] r_data_s, w_data_nx;
    logic [N_DIGIT-1:0]   r_dot_s, w_dot_nx;
    logic                 r_lzs_s, w_lzs_nx;
    logic [BRIGHT_W:0]    r_bright_s, w_bright_nx;
    logic                 w_load;
    logic [N_DIGIT-1:0]   w_sup_mask;
    logic [3:0]           w_nib;
    logic [6:0]           w_font;
    logic [7:0]           w_seg_raw;
    logic [N_DIGIT-1:0]   w_com_raw;
    logic                 r_frame;
    logic [7:0]           r_seg_d;
    logic [N_DIGIT-1:0]   r_com;

    // Bright values above the slot length saturate naturally in the compare.
    function automatic seg_state_t slot_state(input logic [BRIGHT_W-1:0] sub,
                                              input logic [BRIGHT_W:0]   bright);
        if (int'(sub) < DEAD_TICKS) return S_DEAD;
        if ({1'b0, sub} < bright)   return S_ON;
        return S_DIM;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_sub_nx   = r_sub_cnt;
        w_dig_nx   = r_dig_idx;
        w_load     = 1'b0;
        if (r_state == S_OFF) begin
            if (bus.i_en) begin
                w_state_nx = S_DEAD;
                w_sub_nx   = '0;
                w_dig_nx   = DIG_LAST;
                w_load     = 1'b1;
            end
        end else if (!bus.i_en) begin
            w_state_nx = S_OFF;
            w_sub_nx   = '0;
            w_dig_nx   = '0;
        end else if (bus.i_pls_tick) begin
            w_sub_nx = r_sub_cnt + 1'b1;
            if (r_sub_cnt == SUB_LAST) begin
                if (r_dig_idx == '0) begin
                    w_dig_nx = DIG_LAST;
                    w_load   = 1'b1;
                end else begin
                    w_dig_nx = r_dig_idx - 1'b1;
                end
            end
            w_state_nx = slot_state(w_sub_nx, w_load ? bus.i_bright : r_bright_s);
        end
    end

    assign w_data_nx   = w_load ? bus.i_data   : r_data_s;
    assign w_dot_nx    = w_load ? bus.i_dot    : r_dot_s;
    assign w_lzs_nx    = w_load ? bus.i_lzs_en : r_lzs_s;
    assign w_bright_nx = w_load ? bus.i_bright : r_bright_s;

    // Digit k>0 blanks when it and every more-significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_sup_mask = '0;
        for (int k = N_DIGIT - 1; k > 0; k--) begin
            zero_above    = zero_above & (w_data_nx[4*k +: 4] == 4'h0);
            w_sup_mask[k] = zero_above & w_lzs_nx;
        end
    end

    assign w_nib = w_data_nx[4*w_dig_nx +: 4];

    seg_hex_font u_font (
        .i_nib (w_nib),
        .o_seg (w_font)
    );

    assign w_seg_raw = (w_state_nx == S_ON)
                     ? {w_dot_nx[w_dig_nx], (w_sup_mask[w_dig_nx] ? 7'h00 : w_font)}
                     : 8'h00;
    assign w_com_raw = (w_state_nx == S_ON) ? (N_DIGIT'(1) << w_dig_nx) : '0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_OFF;
            r_sub_cnt  <= '0;
            r_dig_idx  <= '0;
            r_data_s   <= '0;
            r_dot_s    <= '0;
            r_lzs_s    <= 1'b0;
            r_bright_s <= '0;
            r_frame    <= 1'b0;
            r_seg_d    <= SEG_IDLE;
            r_com      <= COM_IDLE;
        end else begin
            r_state    <= w_state_nx;
            r_sub_cnt  <= w_sub_nx;
            r_dig_idx  <= w_dig_nx;
            r_data_s   <= w_data_nx;
            r_dot_s    <= w_dot_nx;
            r_lzs_s    <= w_lzs_nx;
            r_bright_s <= w_bright_nx;
            r_frame    <= w_load;
            r_seg_d    <= w_seg_raw ^ SEG_IDLE;
            r_com      <= w_com_raw ^ COM_IDLE;
        end
    end

    assign bus.o_seg_d       = r_seg_d;
    assign bus.o_seg_com     = r_com;
    assign bus.o_frame_start = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: an active-high and an active-low instance
// share one directed stimulus stream; a monitor checks both every clock.
module tb_seg_scan_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.N_DIGIT(8), .BRIGHT_W(2)) bus_h ();
    seg_scan_ctrl_if #(.N_DIGIT(8), .BRIGHT_W(2)) bus_l ();

    seg_scan_ctrl #(
        .N_DIGIT(8), .BRIGHT_W(2), .DEAD_TICKS(1), .SEG_ACT_LOW(1'b0), .COM_ACT_LOW(1'b0)
    ) dut_h (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus_h)
    );

    seg_scan_ctrl #(
        .N_DIGIT(8), .BRIGHT_W(2), .DEAD_TICKS(1), .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)
    ) dut_l (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus_l)
    );

    typedef struct {
        logic [7:0] seg;
        logic [7:0] com;
        logic       fs;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got seg=%02h com=%02h fs=%0d, expected seg=%02h com=%02h fs=%0d",
                     name, act[16:9], act[8:1], act[0], exp[16:9], exp[8:1], exp[0]);
        end
    endtask

    // Monitor: one expectation per clock, checked #1 after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "/hi"}, {bus_h.o_seg_d, bus_h.o_seg_com, bus_h.o_frame_start},
                      {e.seg, e.com, e.fs});
                check({e.name, "/lo"}, {bus_l.o_seg_d, bus_l.o_seg_com, bus_l.o_frame_start},
                      {~e.seg, ~e.com, e.fs});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic set_inputs(input logic [31:0] d, input logic [7:0] dot,
                              input logic lzs, input logic [2:0] br);
        bus_h.i_data = d;   bus_l.i_data = d;
        bus_h.i_dot = dot;  bus_l.i_dot = dot;
        bus_h.i_lzs_en = lzs; bus_l.i_lzs_en = lzs;
        bus_h.i_bright = br; bus_l.i_bright = br;
    endtask

    task automatic cyc(input logic en, input logic tick, input logic [7:0] seg,
                       input logic [7:0] com, input logic fs, input string name);
        @(negedge clk);
        bus_h.i_en = en;         bus_l.i_en = en;
        bus_h.i_pls_tick = tick; bus_l.i_pls_tick = tick;
        q.push_back('{seg: seg, com: com, fs: fs, name: name});
    endtask

    // Walks one full frame (32 ticks) from slot 7 tick 0; next-frame inputs change in slot 5.
    task automatic run_frame(input logic [63:0] tab, input logic [3:0] on_mask, input string tag,
                             input logic [31:0] nd, input logic [7:0] ndot,
                             input logic nlzs, input logic [2:0] nbr);
        for (int p = 1; p <= 32; p++) begin
            int         slot;
            int         sub;
            logic [7:0] es;
            logic [7:0] ec;
            slot = 7 - p / 4;
            sub  = p % 4;
            if (p == 9) set_inputs(nd, ndot, nlzs, nbr);
            if (p == 32) begin
                cyc(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, {tag, "_wrap"});
            end else begin
                es = on_mask[sub] ? tab[8*slot +: 8] : 8'h00;
                ec = on_mask[sub] ? (8'(1) << slot) : 8'h00;
                cyc(1'b1, 1'b1, es, ec, 1'b0, $sformatf("%s_d%0d_t%0d", tag, slot, sub));
                if (p == 2) cyc(1'b1, 1'b0, es, ec, 1'b0, {tag, "_hold"});
            end
        end
    endtask

    initial begin
        set_inputs(32'h0000_1234, 8'h00, 1'b1, 3'd4);
        bus_h.i_en = 1'b0;       bus_l.i_en = 1'b0;
        bus_h.i_pls_tick = 1'b0; bus_l.i_pls_tick = 1'b0;

        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "reset0");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "reset1");
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "reset_en_ignored");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "idle_after_reset");
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "off_idle");
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "en_load");
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "dead_no_tick");

        run_frame(64'h00000000_065B4F66, 4'b1110, "f1", 32'h0000_0008, 8'h01, 1'b1, 3'd2);
        run_frame(64'h00000000_000000FF, 4'b0010, "f2", 32'h0F00_00A0, 8'h80, 1'b0, 3'd7);
        run_frame(64'hBF713F3F_3F3F773F, 4'b1110, "f3", 32'hFFFF_FFFF, 8'hFF, 1'b0, 3'd1);
        run_frame(64'h0, 4'b0000, "f4_br1", 32'hFFFF_FFFF, 8'hFF, 1'b0, 3'd0);
        run_frame(64'h0, 4'b0000, "f5_br0", 32'h0000_1234, 8'h00, 1'b1, 3'd4);

        cyc(1'b1, 1'b1, 8'h00, 8'h80, 1'b0, "f6_d7_on");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "en_drop");
        cyc(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, "off_tick_ignored");
        cyc(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, "en_tick_load");
        cyc(1'b1, 1'b1, 8'h00, 8'h80, 1'b0, "restart_d7_t1");
        cyc(1'b1, 1'b1, 8'h00, 8'h80, 1'b0, "restart_d7_t2");
        cyc(1'b1, 1'b1, 8'h00, 8'h80, 1'b0, "restart_d7_t3");
        cyc(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, "restart_d6_t0");
        cyc(1'b1, 1'b1, 8'h00, 8'h40, 1'b0, "restart_d6_t1");

        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("async_rst/hi", {bus_h.o_seg_d, bus_h.o_seg_com, bus_h.o_frame_start}, {8'h00, 8'h00, 1'b0});
        check("async_rst/lo", {bus_l.o_seg_d, bus_l.o_seg_com, bus_l.o_frame_start}, {8'hFF, 8'hFF, 1'b0});

        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "in_reset");
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "rst_release_off");
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "still_off");
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "post_rst_load");
        cyc(1'b1, 1'b1, 8'h00, 8'h80, 1'b0, "post_rst_d7_on");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
